// File: rtl/glyph_row_serializer.sv
// rtl/glyph_row_serializer.sv - glyph ROM row fetch with scaled/inverted pixel serializer
module glyph_row_serializer #(
  parameter int GLYPH_W    = 16,
  parameter int GLYPH_H    = 16,
  parameter int NUM_GLYPHS = 16,
  parameter int IDX_W      = 4,
  parameter int ROW_W      = 4,
  parameter logic [NUM_GLYPHS*GLYPH_H*GLYPH_W-1:0] FONT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_glyph,
  input  logic [ROW_W-1:0] req_row,
  input  logic [1:0]       req_scale,
  input  logic             req_invert,
  output logic             px_valid,
  input  logic             px_ready,
  output logic             px_on,
  output logic             px_last,
  output logic             busy
);

  localparam int DEPTH = NUM_GLYPHS * GLYPH_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   glyph_q;
  logic [ROW_W-1:0]   row_q;
  logic [1:0]         scale_q;
  logic               invert_q;
  logic [GLYPH_W-1:0] rom_q;
  logic [GLYPH_W-1:0] shreg;
  logic [CW-1:0]      bit_cnt;
  logic [1:0]         rep_cnt;
  logic               in_range;
  logic [AW-1:0]      addr;
  logic [GLYPH_W-1:0] rom [DEPTH];

  // Glyph 0 row 0 sits in the MSBs of FONT, so word i counts down from the top.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = FONT[(DEPTH-1-i)*GLYPH_W +: GLYPH_W];
  end

  assign in_range = (int'(glyph_q) < NUM_GLYPHS) && (int'(row_q) < GLYPH_H);
  assign addr     = AW'(int'(glyph_q) * GLYPH_H + int'(row_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    px_valid  = 1'b0;
    px_on     = 1'b0;
    px_last   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = FETCH;
      end
      FETCH: state_nx = LOAD;
      LOAD:  state_nx = SHIFT;
      SHIFT: begin
        px_valid = 1'b1;
        px_on    = shreg[GLYPH_W-1] ^ invert_q;
        px_last  = (bit_cnt == '0) && (rep_cnt == 2'd0);
        if (px_ready && px_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_q  <= '0;
      row_q    <= '0;
      scale_q  <= '0;
      invert_q <= 1'b0;
      rom_q    <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            glyph_q  <= req_glyph;
            row_q    <= req_row;
            scale_q  <= req_scale;
            invert_q <= req_invert;
          end
        end
        FETCH: rom_q <= in_range ? rom[addr] : '0;
        LOAD: begin
          shreg   <= rom_q;
          bit_cnt <= CW'(GLYPH_W - 1);
          rep_cnt <= scale_q;
        end
        SHIFT: begin
          // Each pixel is held for scale+1 accepted beats before the register shifts.
          if (px_ready) begin
            if (rep_cnt != 2'd0) begin
              rep_cnt <= rep_cnt - 2'd1;
            end else begin
              rep_cnt <= scale_q;
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
